hififo_interrupt_ctrl: RTL

//  Interrupt scheduler between the per-FIFO engines and the PCIe core MSI port.

---
 rtl/hififo_interrupt_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hififo_interrupt_ctrl.sv
// Round-robin MSI scheduler: collects per-FIFO event pulses, masks them with a
// PIO enable register and issues one interrupt at a time with a post-accept holdoff.
module hififo_interrupt_ctrl #(
  parameter logic [10:0] ADDR_ENABLE = 11'd9,
  parameter int unsigned HOLDOFF     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pio_wvalid,
  input  logic [10:0] pio_addr,
  input  logic [63:0] pio_wdata,
  input  logic [7:0]  events,
  input  logic [2:0]  interrupts_enabled,
  output logic        interrupt,
  output logic [3:0]  interrupt_num,
  input  logic        interrupt_rdy,
  output logic [7:0]  pending,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is presented by holding interrupt=1 with a stable
  // interrupt_num; it is consumed on the first clock edge where interrupt and
  // interrupt_rdy are both 1. interrupt_rdy has no effect at any other time.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  state_t      state, state_next;
  logic [7:0]  enable, enable_next;
  logic [7:0]  pending_next, clear_mask;
  logic [7:0]  hold_cnt, hold_next;
  logic [2:0]  last_grant, last_next;
  logic        interrupt_next;
  logic [3:0]  num_next;
  logic [2:0]  grant;
  logic        grant_found;
  logic [2:0]  vec_mask;
  logic        pio_hit;
  logic        accept;
  logic        unused_wdata;

  assign unused_wdata = ^pio_wdata[63:16];
  assign dbg_state    = state;
  assign pio_hit      = pio_wvalid && (pio_addr == ADDR_ENABLE);
  assign accept       = (state == ST_ASSERT) && interrupt && interrupt_rdy;

  function automatic logic [3:0] vec_of(input logic [2:0] fifo, input logic [2:0] mask);
    return {1'b0, fifo & mask};
  endfunction

  always_comb begin
    case (interrupts_enabled)
      3'd0:    vec_mask = 3'b000;
      3'd1:    vec_mask = 3'b001;
      3'd2:    vec_mask = 3'b011;
      default: vec_mask = 3'b111;
    endcase
  end

  // Search starts just after the previous winner so every FIFO gets a turn.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!grant_found && pending[last_grant + 3'(k)]) begin
        grant       = last_grant + 3'(k);
        grant_found = 1'b1;
      end
    end
  end

  // Sets are applied after clears so a same-cycle event keeps its bit.
  always_comb begin
    enable_next = pio_hit ? pio_wdata[7:0] : enable;
    clear_mask  = '0;
    if (pio_hit) begin
      clear_mask = pio_wdata[15:8] | (enable & ~pio_wdata[7:0]);
    end
    if (accept) begin
      for (int j = 0; j < 8; j++) begin
        if (vec_of(3'(j), vec_mask) == interrupt_num) clear_mask[j] = 1'b1;
      end
    end
    pending_next = (pending & ~clear_mask) | (events & enable);
  end

  always_comb begin
    state_next     = state;
    interrupt_next = interrupt;
    num_next       = interrupt_num;
    hold_next      = hold_cnt;
    last_next      = last_grant;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          interrupt_next = 1'b1;
          num_next       = vec_of(grant, vec_mask);
          last_next      = grant;
          state_next     = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (interrupt_rdy) begin
          interrupt_next = 1'b0;
          hold_next      = HOLD_LOAD;
          state_next     = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt == 8'd0) state_next = ST_IDLE;
        else                  hold_next  = hold_cnt - 8'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      enable        <= '0;
      pending       <= '0;
      hold_cnt      <= '0;
      last_grant    <= 3'd7;
      interrupt     <= 1'b0;
      interrupt_num <= '0;
    end else begin
      state         <= state_next;
      enable        <= enable_next;
      pending       <= pending_next;
      hold_cnt      <= hold_next;
      last_grant    <= last_next;
      interrupt     <= interrupt_next;
      interrupt_num <= num_next;
    end
  end

endmodule
